cpu_ctrl_fsm: RTL and testbench



---
 rtl/cpu_ctrl_fsm_pkg.sv | 39 +++
 rtl/cpu_ctrl_fsm_if.sv | 25 ++
 rtl/cpu_ctrl_fsm_regfile.sv | 34 +++
 rtl/cpu_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcodes, FSM states,
// instruction field positions and small decode helpers.
package cpu_pkg;

    localparam int REG_AW = 3;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_LI   = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BLT  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam int OPC_MSB = 31;
    localparam int RD_MSB  = 28;
    localparam int RS1_MSB = 25;
    localparam int RS2_MSB = 22;
    localparam int IMM_W   = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    function automatic logic writes_reg(input logic [2:0] op);
        return (op == OP_LI) || (op >= OP_ADD);
    endfunction

    function automatic logic is_branch(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BLT);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction-memory and ALU connections of the CPU control unit.
// master = control unit (fetch initiator, ALU driver); slave = memory + ALU side.
interface cpu_ctrl_fsm_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     alu_ip_0;
    logic [31:0]     alu_ip_1;
    logic [2:0]      alu_opcode;
    logic [31:0]     alu_op_0;
    logic            alu_change_pc;

    modport master (
        output imem_req, imem_addr, alu_ip_0, alu_ip_1, alu_opcode,
        input  imem_ack, imem_rdata, alu_op_0, alu_change_pc
    );

    modport slave (
        input  imem_req, imem_addr, alu_ip_0, alu_ip_1, alu_opcode,
        output imem_ack, imem_rdata, alu_op_0, alu_change_pc
    );
endinterface

// File: rtl/cpu_ctrl_fsm_regfile.sv
// 8x32 register file: two combinational read ports, one synchronous write port,
// R0 reads as zero and ignores writes.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_0,
    input  logic [REG_AW-1:0] rd_addr_1,
    output logic [31:0]       rd_data_0,
    output logic [31:0]       rd_data_1,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    logic [31:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_0 = (rd_addr_0 == '0) ? '0 : regs[rd_addr_0];
    assign rd_data_1 = (rd_addr_1 == '0) ? '0 : regs[rd_addr_1];

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction.
// Optional retired-instruction counter enabled by defining CPU_CTRL_PERF_CNT_EN.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              NREGS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_ctrl_fsm_if.master        bus,
    output logic                  halted
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           retired_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic [PC_W-1:0]   pc;
    logic [31:0]       instr;
    logic [31:0]       result_q;
    logic              flag_q;

    logic [2:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
    logic [31:0]       imm_sext;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
    logic              reg_we;

    assign opcode   = instr[OPC_MSB -: 3];
    assign rd       = instr[RD_MSB -: REG_AW];
    assign rs1      = instr[RS1_MSB -: REG_AW];
    assign rs2      = instr[RS2_MSB -: REG_AW];
    assign imm      = instr[IMM_W-1:0];
    assign imm_sext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};

    assign bus.imem_addr = pc;
    assign reg_we        = (state == ST_WRITEBACK) && writes_reg(opcode);

    cpu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_0 (rs1),
        .rd_addr_1 (rs2),
        .rd_data_0 (rs1_data),
        .rd_data_1 (rs2_data),
        .wr_en     (reg_we),
        .wr_addr   (rd),
        .wr_data   (result_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // imem_req and halted depend on state alone so a stalled fetch holds them steady
    always_comb begin
        state_next   = state;
        bus.imem_req = 1'b0;
        halted       = 1'b0;
        unique case (state)
            ST_IDLE:      state_next = ST_FETCH;
            ST_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE:    state_next = (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_FETCH;
            ST_HALT:      halted     = 1'b1;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            instr          <= '0;
            result_q       <= '0;
            flag_q         <= 1'b0;
            bus.alu_ip_0   <= '0;
            bus.alu_ip_1   <= '0;
            bus.alu_opcode <= '0;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        instr <= bus.imem_rdata;
                    end
                end
                ST_DECODE: begin
                    bus.alu_opcode <= opcode;
                    if (opcode == OP_LI) begin
                        bus.alu_ip_0 <= {{(32-IMM_W){1'b0}}, imm};
                        bus.alu_ip_1 <= '0;
                    end else begin
                        bus.alu_ip_0 <= rs1_data;
                        bus.alu_ip_1 <= rs2_data;
                    end
                end
                ST_EXECUTE: begin
                    result_q <= bus.alu_op_0;
                    flag_q   <= bus.alu_change_pc;
                end
                ST_WRITEBACK: begin
                    // offsets are truncated to PC width so branches wrap like PC+1 does
                    if (is_branch(opcode) && flag_q) begin
                        pc <= pc + imm_sext[PC_W-1:0];
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
        end else if (state == ST_WRITEBACK) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: instruction-level reference model with a
// per-cycle compare, directed programs and randomized programs.
`timescale 1ns/1ps
module tb_cpu_ctrl_fsm;

    localparam int PC_W = 16;

    typedef struct {
        logic [31:0] instr;
        int          wait_cyc;
    } prog_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halted;
`ifdef CPU_CTRL_PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    always #5 clk = ~clk;

    cpu_ctrl_fsm_if #(.PC_W(PC_W)) bus ();

    cpu_ctrl_fsm #(.PC_W(PC_W), .RESET_PC(16'h0000), .NREGS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halted (halted)
`ifdef CPU_CTRL_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    // The ALU the control unit drives: plain arithmetic on its inputs
    always_comb begin
        bus.alu_op_0      = '0;
        bus.alu_change_pc = 1'b0;
        case (bus.alu_opcode)
            3'd1: bus.alu_op_0      = bus.alu_ip_0;
            3'd2: bus.alu_change_pc = (bus.alu_ip_0 == bus.alu_ip_1);
            3'd3: bus.alu_change_pc = (bus.alu_ip_0 < bus.alu_ip_1);
            3'd4: bus.alu_op_0      = bus.alu_ip_0 + bus.alu_ip_1;
            3'd5: bus.alu_op_0      = bus.alu_ip_0 - bus.alu_ip_1;
            3'd6: bus.alu_op_0      = bus.alu_ip_0 & bus.alu_ip_1;
            3'd7: bus.alu_op_0      = bus.alu_ip_0 | bus.alu_ip_1;
            default: ;
        endcase
    end

    // Reference model state: architectural registers/PC plus edge countdowns
    // saying when each effect of an accepted instruction becomes visible
    logic [31:0] m_regs [8];
    logic [15:0] m_pc;
    bit          m_stop;
    int          fetch_in, halt_cnt, dec_cnt, ret_cnt, fetch_wait;
    logic [2:0]  exp_op, pend_op;
    logic [31:0] exp_a, exp_b, pend_a, pend_b;
    logic [31:0] exp_retired;
    logic [15:0] pc_trace [$];
    int          edge_cnt, halt_seen_at;
    prog_t       prog_q [$];
    int          checks = 0;
    int          errors = 0;
    int          exp_trace [20] = '{0, 1, 2, 3, 4, 5, 3, 4, 5, 6, 7, 8, 9, 10, 14, 10, 11, 0, 65535, 0};

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                        input int rs2, input logic [19:0] imm);
        logic [2:0] o, d, s1, s2;
        o = 3'(op); d = 3'(rd); s1 = 3'(rs1); s2 = 3'(rs2);
        return {o, d, s1, s2, imm};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pc = '0; m_stop = 0;
        fetch_in = 1; halt_cnt = 0; dec_cnt = 0; ret_cnt = 0; fetch_wait = -1;
        exp_op = '0; exp_a = '0; exp_b = '0;
        pend_op = '0; pend_a = '0; pend_b = '0;
        exp_retired = '0;
        pc_trace.delete();
        edge_cnt = 0; halt_seen_at = -1;
    endfunction

    function automatic bit model_req();
        return !m_stop && (fetch_in == 0);
    endfunction

    function automatic bit model_halted();
        return m_stop && (halt_cnt == 0);
    endfunction

    // Whole-instruction semantics applied at the moment of fetch acceptance
    function automatic void model_accept(input logic [31:0] instr);
        logic [2:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic [19:0] imm;
        logic [31:0] a, b, res, off;
        bit          flag;
        op = instr[31:29]; rd = instr[28:26]; rs1 = instr[25:23]; rs2 = instr[22:20];
        imm = instr[19:0];
        if (op == 3'd1) begin
            a = {12'd0, imm}; b = '0;
        end else begin
            a = m_regs[rs1]; b = m_regs[rs2];
        end
        pend_op = op; pend_a = a; pend_b = b; dec_cnt = 1;
        pc_trace.push_back(m_pc);
        if (op == 3'd0) begin
            m_stop = 1; halt_cnt = 1;
        end else begin
            case (op)
                3'd1: res = a;
                3'd4: res = a + b;
                3'd5: res = a - b;
                3'd6: res = a & b;
                3'd7: res = a | b;
                default: res = '0;
            endcase
            flag = (op == 3'd2) ? (a == b) : (op == 3'd3) ? (a < b) : 1'b0;
            if ((op == 3'd1 || op >= 3'd4) && rd != 3'd0) m_regs[rd] = res;
            off  = {{12{imm[19]}}, imm};
            m_pc = flag ? (m_pc + off[15:0]) : (m_pc + 16'd1);
            fetch_in = 3; ret_cnt = 3;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, then drive the memory for the coming edge and advance the model
    always @(negedge clk) begin
        logic        ack_drv;
        logic [31:0] rd_drv;
        bit          req_now;
        if (!rst_n) begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = '0;
        end else begin
            req_now = model_req();
            checkOutput("imem_req", 32'(bus.imem_req), 32'(req_now));
            if (req_now) checkOutput("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
            checkOutput("halted", 32'(halted), 32'(model_halted()));
            checkOutput("alu_opcode", 32'(bus.alu_opcode), 32'(exp_op));
            checkOutput("alu_ip_0", bus.alu_ip_0, exp_a);
            checkOutput("alu_ip_1", bus.alu_ip_1, exp_b);
`ifdef CPU_CTRL_PERF_CNT_EN
            checkOutput("retired_cnt", retired_cnt, exp_retired);
`endif
            if (halted === 1'b1 && halt_seen_at < 0) halt_seen_at = edge_cnt;

            ack_drv = 1'b0;
            rd_drv  = $urandom;
            if (req_now) begin
                if (prog_q.size() > 0) begin
                    if (fetch_wait < 0) fetch_wait = prog_q[0].wait_cyc;
                    if (fetch_wait == 0) begin
                        ack_drv = 1'b1;
                        rd_drv  = prog_q[0].instr;
                    end else begin
                        fetch_wait--;
                    end
                end
            end else begin
                ack_drv = 1'($urandom_range(0, 1));
            end
            bus.imem_ack   = ack_drv;
            bus.imem_rdata = rd_drv;

            if (dec_cnt > 0) begin
                dec_cnt--;
                if (dec_cnt == 0) begin
                    exp_op = pend_op; exp_a = pend_a; exp_b = pend_b;
                end
            end
            if (halt_cnt > 0) halt_cnt--;
            if (fetch_in > 0) fetch_in--;
            if (ret_cnt > 0) begin
                ret_cnt--;
                if (ret_cnt == 0) exp_retired = exp_retired + 32'd1;
            end
            if (req_now && ack_drv) begin
                model_accept(prog_q.pop_front().instr);
                fetch_wait = -1;
            end
            edge_cnt++;
        end
    end

    task automatic startReset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        prog_q.delete();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] instr, input int wait_cyc);
        prog_t p;
        p.instr = instr; p.wait_cyc = wait_cyc;
        prog_q.push_back(p);
    endtask

    // Release reset, let the queued program run to HALT within a cycle budget
    task automatic applyStimulus(input int max_cycles);
        bit done;
        releaseReset();
        done = 0;
        for (int c = 0; c < max_cycles; c++) begin
            if (model_halted() && prog_q.size() == 0) begin
                done = 1;
                break;
            end
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halt_reached", 32'(done), 32'd1);
    endtask

    initial begin
        model_reset();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        #12;
        checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
        checkOutput("reset_imem_addr", 32'(bus.imem_addr), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_alu_opcode", 32'(bus.alu_opcode), 32'd0);

        // LI R1,5; LI R2,3; ADD R3,R1,R2; HALT with immediate acks
        startReset();
        push(enc(1, 1, 0, 0, 20'd5), 0);
        push(enc(1, 2, 0, 0, 20'd3), 0);
        push(enc(4, 3, 1, 2, 20'd0), 0);
        push(enc(0, 0, 0, 0, 20'd0), 0);
        applyStimulus(100);
        checkOutput("t1_halt_edge", 32'(halt_seen_at), 32'd15);
        checkOutput("t1_model_r3", m_regs[3], 32'd8);
`ifdef CPU_CTRL_PERF_CNT_EN
        checkOutput("t1_retired", retired_cnt, 32'd3);
        checkOutput("t1_model_retired", exp_retired, 32'd3);
`endif

        // SUB/AND/OR, R0 write discard, results exposed through later operands
        startReset();
        push(enc(1, 1, 0, 0, 20'hF0), 3);
        push(enc(1, 2, 0, 0, 20'h3C), 0);
        push(enc(5, 4, 1, 2, 20'd0), 1);
        push(enc(6, 5, 1, 2, 20'd0), 0);
        push(enc(7, 6, 1, 2, 20'd0), 2);
        push(enc(1, 0, 0, 0, 20'd7), 0);
        push(enc(4, 7, 0, 0, 20'd0), 0);
        push(enc(7, 0, 4, 5, 20'd0), 0);
        push(enc(7, 0, 6, 7, 20'd0), 0);
        push(enc(0, 0, 0, 0, 20'd0), 0);
        applyStimulus(200);
        checkOutput("t2_model_r4", m_regs[4], 32'h0000_00B4);
        checkOutput("t2_model_r5", m_regs[5], 32'h0000_0030);
        checkOutput("t2_model_r6", m_regs[6], 32'h0000_00FC);
        checkOutput("t2_model_r7", m_regs[7], 32'h0000_0000);

        // Branch program including PC wrap in both directions
        startReset();
        push(enc(1, 1, 0, 0, 20'd5), 0);
        push(enc(1, 2, 0, 0, 20'd3), 0);
        for (int i = 0; i < 3; i++) push(enc(7, 0, 0, 0, 20'd0), 0);
        push(enc(2, 0, 1, 1, 20'hFFFFE), 0);
        for (int i = 0; i < 7; i++) push(enc(7, 0, 0, 0, 20'd0), 0);
        push(enc(3, 0, 2, 1, 20'd4), 0);
        push(enc(2, 0, 0, 0, 20'hFFFFC), 0);
        push(enc(3, 0, 1, 2, 20'd4), 0);
        push(enc(2, 0, 0, 0, 20'hFFFF5), 0);
        push(enc(2, 0, 0, 0, 20'hFFFFF), 0);
        push(enc(7, 0, 0, 0, 20'd0), 0);
        push(enc(0, 0, 0, 0, 20'd0), 0);
        applyStimulus(300);
        checkOutput("t3_trace_len", 32'(pc_trace.size()), 32'd20);
        for (int i = 0; i < 20 && i < pc_trace.size(); i++)
            checkOutput($sformatf("t3_pc_trace_%0d", i), 32'(pc_trace[i]), 32'(exp_trace[i]));

        // Reset asserted while a fetch is stalled waiting for ack
        begin
            int n;
            startReset();
            push(enc(1, 1, 0, 0, 20'd9), 0);
            push(enc(1, 2, 0, 0, 20'd1), 10);
            @(posedge clk);
            #2 rst_n = 1'b1;
            n = 0;
            while (pc_trace.size() == 0 && n < 20) begin
                @(posedge clk);
                n++;
            end
            checkOutput("t4_first_fetch", 32'(pc_trace.size()), 32'd1);
            repeat (6) @(posedge clk);
            checkOutput("t4_pre_addr", 32'(bus.imem_addr), 32'd1);
            #2 rst_n = 1'b0;
            #1;
            checkOutput("t4_rst_imem_req", 32'(bus.imem_req), 32'd0);
            checkOutput("t4_rst_imem_addr", 32'(bus.imem_addr), 32'd0);
            checkOutput("t4_rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
            checkOutput("t4_rst_alu_ip_0", bus.alu_ip_0, 32'd0);
            model_reset();
            prog_q.delete();
            push(enc(1, 1, 0, 0, 20'd9), 0);
            push(enc(0, 0, 0, 0, 20'd0), 0);
            applyStimulus(100);
            checkOutput("t4_trace_len", 32'(pc_trace.size()), 32'd2);
            if (pc_trace.size() > 0) checkOutput("t4_refetch_addr", 32'(pc_trace[0]), 32'd0);
`ifdef CPU_CTRL_PERF_CNT_EN
            checkOutput("t4_retired", retired_cnt, 32'd1);
`endif
        end

        // Randomized programs with random fetch latency
        for (int r = 0; r < 3; r++) begin
            startReset();
            for (int i = 0; i < 30; i++)
                push(enc(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         20'($urandom)), int'($urandom_range(0, 3)));
            push(enc(0, 0, 0, 0, 20'd0), int'($urandom_range(0, 2)));
            applyStimulus(400);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
